rc_int_fifo_bank: RTL and testbench
===================================

RC_INT_FIFO_BANK -- requirements
Module: rc_int_fifo_bank

Interface
REQ-001 SHALL have parameter NumRcInt, default 8, meaning the number of independent interrupt-record FIFO channels.
REQ-002 SHALL have parameter DataWidth, default 8, meaning the record width per channel.
REQ-003 SHALL have parameter Depth, default 4, meaning entries per channel; the legal range is 1..7.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state is rising-edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port push_valid, input, [NumRcInt-1:0]: per-channel write request.
REQ-007 SHALL have port push_data, input, [NumRcInt-1:0][DataWidth-1:0]: per-channel write record.
REQ-008 SHALL have port push_ready, output, [NumRcInt-1:0]: per-channel space available.
REQ-009 SHALL have port pop_valid, output, [NumRcInt-1:0]: per-channel record available.
REQ-010 SHALL have port pop_data, output, [NumRcInt-1:0][DataWidth-1:0]: per-channel head record.
REQ-011 SHALL have port pop_ready, input, [NumRcInt-1:0]: per-channel read acknowledge.
REQ-012 SHALL have port int_thresh, input, [2:0]: shared occupancy threshold for irq.
REQ-013 SHALL have port amf_rc_int_fifo_level, output, [NumRcInt-1:0][2:0]: per-channel occupancy, feeding the downstream level consumer.
REQ-014 SHALL have port irq, output, [NumRcInt-1:0]: per-channel registered threshold interrupt.
REQ-015 SHALL have port ovf, output, [NumRcInt-1:0]: per-channel sticky overflow flag.
REQ-016 SHALL have port ovf_clr, input, [NumRcInt-1:0]: per-channel overflow clear pulse.

Function
REQ-017 Each channel SHALL be a Depth-entry FIFO that is independent of every other channel.
REQ-018 A push SHALL occur when push_valid[i] && push_ready[i]; a pop SHALL occur when pop_valid[i] && pop_ready[i].
REQ-019 push_ready[i] SHALL be combinational, equal to (level[i] < Depth); there is no push-through-when-full, even when a pop happens in the same cycle.
REQ-020 pop_valid[i] SHALL equal (level[i] != 0); pop_data[i] SHALL be the oldest entry, valid whenever pop_valid[i] is high, and don't-care otherwise.
REQ-021 Level update SHALL be: push only gives +1; pop only gives -1; push and pop together leaves it unchanged, with data written and read in the same cycle.
REQ-022 A record pushed at cycle N SHALL be poppable at cycle N+1 (one-cycle latency); the FIFO SHALL NOT bypass same-cycle data.
REQ-023 Read and write pointers SHALL wrap modulo Depth, including when Depth is not a power of two.
REQ-024 amf_rc_int_fifo_level[i] SHALL be the registered level counter, reflecting all pushes and pops of the previous edge, with range 0..Depth.
REQ-025 irq[i] SHALL be registered: on each edge it loads (int_thresh != 0) && (next level[i] >= int_thresh), so irq asserts in the same cycle the level output reaches the threshold.
REQ-026 int_thresh = 0 SHALL disable irq on all channels; int_thresh > Depth SHALL keep irq permanently low.
REQ-027 ovf[i] SHALL set on any edge where push_valid[i] && !push_ready[i]; the dropped record SHALL NOT alter FIFO contents or level.
REQ-028 ovf[i] SHALL clear on an edge with ovf_clr[i] high; simultaneous set and clear SHALL leave ovf[i] = 1.
REQ-029 pop_ready[i] while empty SHALL be ignored, with no underflow and no level change.

Reset
REQ-030 While rst is high, the following SHALL be forced asynchronously to zero for all channels: level, pointers, amf_rc_int_fifo_level, irq and ovf; push_ready SHALL then be all ones and pop_valid all zeros.
REQ-031 Reset mid-operation SHALL discard all stored records; the first push after reset deassertion SHALL be returned first.
REQ-032 FIFO storage contents need not be reset.

Verification
REQ-033 Reset, then push 0x11,0x22,0x33 on ch0 in consecutive cycles with no pop -> level[0] goes 1,2,3; pops return 0x11,0x22,0x33 in order; other channels' levels stay 0.
REQ-034 Fill ch3 to 4 (Depth=4), hold push_valid with 0xAA for one more cycle -> push_ready[3]=0, ovf[3]=1 next cycle, level stays 4, 0xAA never popped; ovf_clr[3] and a new overflow in the same cycle -> ovf[3] stays 1.
REQ-035 Level 2 on ch5, simultaneous push/pop for 6 cycles -> level[5] constant 2; pointers wrap; order preserved.
REQ-036 int_thresh=3, push ch1 to 3 -> irq[1] rises with level=3; one pop -> irq[1] falls with level=2; int_thresh=0 -> irq all zero.
REQ-037 rst asserted asynchronously with ch0..ch7 at level 2 -> all levels, irq and ovf read 0 before the next edge; a post-reset push of 0x5C pops as 0x5C.
REQ-038 Pop on an empty channel with pop_ready=1 for 3 cycles -> level stays 0 and pop_valid stays 0.

Source files
------------

// File: rtl/rc_int_fifo_bank.sv
// Bank of independent interrupt-record FIFOs. Each channel reports a registered
// occupancy level, a threshold interrupt and a sticky overflow flag.
module rc_int_fifo_bank #(
  parameter int unsigned NumRcInt  = 8,
  parameter int unsigned DataWidth = 8,
  parameter int unsigned Depth     = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NumRcInt-1:0]                push_valid,
  input  logic [NumRcInt-1:0][DataWidth-1:0] push_data,
  output logic [NumRcInt-1:0]                push_ready,
  output logic [NumRcInt-1:0]                pop_valid,
  output logic [NumRcInt-1:0][DataWidth-1:0] pop_data,
  input  logic [NumRcInt-1:0]                pop_ready,
  input  logic [2:0]                         int_thresh,
  output logic [NumRcInt-1:0][2:0]           amf_rc_int_fifo_level,
  output logic [NumRcInt-1:0]                irq,
  output logic [NumRcInt-1:0]                ovf,
  input  logic [NumRcInt-1:0]                ovf_clr
);

  localparam int unsigned     PtrW   = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [2:0]      DepthL = 3'(Depth);
  localparam logic [PtrW-1:0] PtrMax = PtrW'(Depth - 1);

  for (genvar i = 0; i < NumRcInt; i++) begin : g_ch
    logic [2:0]           level_q, level_d;
    logic [PtrW-1:0]      wptr_q, wptr_d, rptr_q, rptr_d;
    logic                 irq_q, irq_d, ovf_q, ovf_d;
    logic                 push, pop;
    logic [DataWidth-1:0] mem_q [Depth];

    assign push_ready[i]            = (level_q < DepthL);
    assign pop_valid[i]             = (level_q != 3'd0);
    assign pop_data[i]              = mem_q[rptr_q];
    assign amf_rc_int_fifo_level[i] = level_q;
    assign irq[i]                   = irq_q;
    assign ovf[i]                   = ovf_q;

    assign push = push_valid[i] && push_ready[i];
    assign pop  = pop_valid[i] && pop_ready[i];

    always_comb begin
      level_d = level_q;
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      ovf_d   = ovf_q;
      if (push && !pop) begin
        level_d = level_q + 3'd1;
      end else if (pop && !push) begin
        level_d = level_q - 3'd1;
      end
      // Explicit wrap so non-power-of-two depths stay in range.
      if (push) begin
        wptr_d = (wptr_q == PtrMax) ? '0 : wptr_q + PtrW'(1);
      end
      if (pop) begin
        rptr_d = (rptr_q == PtrMax) ? '0 : rptr_q + PtrW'(1);
      end
      // Set wins over clear so a dropped record is never lost silently.
      if (push_valid[i] && !push_ready[i]) begin
        ovf_d = 1'b1;
      end else if (ovf_clr[i]) begin
        ovf_d = 1'b0;
      end
      irq_d = (int_thresh != 3'd0) && (level_d >= int_thresh);
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        level_q <= '0;
        wptr_q  <= '0;
        rptr_q  <= '0;
        irq_q   <= 1'b0;
        ovf_q   <= 1'b0;
      end else begin
        level_q <= level_d;
        wptr_q  <= wptr_d;
        rptr_q  <= rptr_d;
        irq_q   <= irq_d;
        ovf_q   <= ovf_d;
      end
    end

    // Storage is deliberately not reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
      if (push) begin
        mem_q[wptr_q] <= push_data[i];
      end
    end
  end

endmodule

// File: tb/tb_rc_int_fifo_bank.sv
// Self-checking bench for rc_int_fifo_bank: per-cycle reference model plus a
// record scoreboard, directed scenarios followed by a random phase.
module tb_rc_int_fifo_bank;
  localparam int N  = 8;
  localparam int DW = 8;
  localparam int D  = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [N-1:0]         push_valid;
  logic [N-1:0][DW-1:0] push_data;
  logic [N-1:0]         push_ready;
  logic [N-1:0]         pop_valid;
  logic [N-1:0][DW-1:0] pop_data;
  logic [N-1:0]         pop_ready;
  logic [2:0]           int_thresh;
  logic [N-1:0][2:0]    amf_rc_int_fifo_level;
  logic [N-1:0]         irq;
  logic [N-1:0]         ovf;
  logic [N-1:0]         ovf_clr;

  rc_int_fifo_bank #(
    .NumRcInt (N),
    .DataWidth(DW),
    .Depth    (D)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .push_valid           (push_valid),
    .push_data            (push_data),
    .push_ready           (push_ready),
    .pop_valid            (pop_valid),
    .pop_data             (pop_data),
    .pop_ready            (pop_ready),
    .int_thresh           (int_thresh),
    .amf_rc_int_fifo_level(amf_rc_int_fifo_level),
    .irq                  (irq),
    .ovf                  (ovf),
    .ovf_clr              (ovf_clr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] ch;
    logic [7:0] data;
  } sb_t;

  sb_t  sb_q[$];
  int   lvl [N];
  logic eirq[N];
  logic eovf[N];
  int   checks = 0;
  int   errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      lvl[i]  = 0;
      eirq[i] = 1'b0;
      eovf[i] = 1'b0;
    end
    sb_q.delete();
  endtask

  // Compare outputs mid-cycle, then advance the model across the next rising edge.
  task automatic step();
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      logic pr, pv;
      int   idx, nl;
      pr = (lvl[i] < D);
      pv = (lvl[i] != 0);
      check_eq($sformatf("push_ready[%0d]", i), 32'(push_ready[i]), 32'(pr));
      check_eq($sformatf("pop_valid[%0d]", i), 32'(pop_valid[i]), 32'(pv));
      check_eq($sformatf("level[%0d]", i), 32'(amf_rc_int_fifo_level[i]), 32'(lvl[i]));
      check_eq($sformatf("irq[%0d]", i), 32'(irq[i]), 32'(eirq[i]));
      check_eq($sformatf("ovf[%0d]", i), 32'(ovf[i]), 32'(eovf[i]));
      nl = lvl[i];
      if (pv && pop_ready[i]) begin
        idx = -1;
        for (int k = 0; k < sb_q.size(); k++) begin
          if (idx < 0 && sb_q[k].ch == 3'(i)) idx = k;
        end
        if (idx < 0) begin
          check_eq($sformatf("pop_unexpected[%0d]", i), 32'(pop_valid[i]), 32'(0));
        end else begin
          check_eq($sformatf("pop_data[%0d]", i), 32'(pop_data[i]), 32'(sb_q[idx].data));
          sb_q.delete(idx);
        end
        nl--;
      end
      if (push_valid[i] && pr) begin
        sb_q.push_back('{ch: 3'(i), data: push_data[i]});
        nl++;
      end
      if (push_valid[i] && !pr) eovf[i] = 1'b1;
      else if (ovf_clr[i])      eovf[i] = 1'b0;
      lvl[i]  = nl;
      eirq[i] = (int_thresh != 3'd0) && (nl >= int'(int_thresh));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    push_valid = '0;
    pop_ready  = '0;
    ovf_clr    = '0;
  endtask

  task automatic drain();
    idle();
    pop_ready = '1;
    repeat (D + 1) step();
    idle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst        = 1'b1;
    push_data  = '0;
    int_thresh = 3'd0;
    idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_level", 32'(amf_rc_int_fifo_level), 32'(0));
    check_eq("rst_push_ready", 32'(push_ready), 32'(8'hFF));
    check_eq("rst_pop_valid", 32'(pop_valid), 32'(0));
    check_eq("rst_irq_ovf", 32'({irq, ovf}), 32'(0));
    rst = 1'b0;
    step();

    // Ordered push then pop on ch0.
    push_valid[0] = 1'b1;
    push_data[0] = 8'h11; step();
    check_eq("ch0_level1", 32'(amf_rc_int_fifo_level[0]), 32'(1));
    push_data[0] = 8'h22; step();
    check_eq("ch0_level2", 32'(amf_rc_int_fifo_level[0]), 32'(2));
    push_data[0] = 8'h33; step();
    check_eq("ch0_level3", 32'(amf_rc_int_fifo_level[0]), 32'(3));
    check_eq("ch0_head", 32'(pop_data[0]), 32'(8'h11));
    drain();

    // Overflow on ch3, set beats clear.
    push_valid[3] = 1'b1;
    for (int k = 0; k < D; k++) begin
      push_data[3] = 8'h30 + 8'(k);
      step();
    end
    push_data[3] = 8'hAA; step();
    check_eq("ch3_ovf_set", 32'(ovf[3]), 32'(1));
    check_eq("ch3_level_full", 32'(amf_rc_int_fifo_level[3]), 32'(4));
    ovf_clr[3] = 1'b1; step();
    check_eq("ch3_ovf_hold", 32'(ovf[3]), 32'(1));
    push_valid[3] = 1'b0; step();
    check_eq("ch3_ovf_clr", 32'(ovf[3]), 32'(0));
    drain();

    // Simultaneous push/pop at level 2 on ch5 wraps the pointers.
    push_valid[5] = 1'b1;
    push_data[5] = 8'h50; step();
    push_data[5] = 8'h51; step();
    pop_ready[5] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      push_data[5] = 8'h52 + 8'(k);
      step();
      check_eq("ch5_level_const", 32'(amf_rc_int_fifo_level[5]), 32'(2));
    end
    drain();

    // Threshold interrupt on ch1.
    int_thresh = 3'd3;
    push_valid[1] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      push_data[1] = 8'h10 + 8'(k);
      step();
      check_eq("ch1_irq_rise", 32'(irq[1]), 32'(k == 2));
    end
    idle();
    pop_ready[1] = 1'b1; step();
    check_eq("ch1_irq_fall", 32'(irq[1]), 32'(0));
    idle();
    step();
    int_thresh = 3'd2;
    step();
    check_eq("ch1_irq_thr2", 32'(irq[1]), 32'(1));
    int_thresh = 3'd0;
    step();
    check_eq("irq_disabled", 32'(irq), 32'(0));
    drain();

    // Popping an empty channel is ignored.
    pop_ready[2] = 1'b1;
    repeat (3) begin
      step();
      check_eq("ch2_empty_level", 32'(amf_rc_int_fifo_level[2]), 32'(0));
      check_eq("ch2_empty_valid", 32'(pop_valid[2]), 32'(0));
    end
    idle();

    // Asynchronous reset with every channel at level 2.
    int_thresh = 3'd1;
    push_valid = '1;
    for (int i = 0; i < N; i++) push_data[i] = 8'h70 + 8'(i);
    step();
    for (int i = 0; i < N; i++) push_data[i] = 8'h80 + 8'(i);
    ovf_clr = '0;
    step();
    idle();
    check_eq("pre_rst_irq", 32'(irq), 32'(8'hFF));
    #2 rst = 1'b1;
    #1;
    check_eq("async_rst_level", 32'(amf_rc_int_fifo_level), 32'(0));
    check_eq("async_rst_irq", 32'(irq), 32'(0));
    check_eq("async_rst_ovf", 32'(ovf), 32'(0));
    check_eq("async_rst_pop_valid", 32'(pop_valid), 32'(0));
    model_reset();
    int_thresh = 3'd0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    push_valid[0] = 1'b1;
    push_data[0]  = 8'h5C;
    step();
    check_eq("post_rst_head", 32'(pop_data[0]), 32'(8'h5C));
    drain();

    // Random traffic on all channels.
    for (int c = 0; c < 400; c++) begin
      if (c % 25 == 0) int_thresh = 3'($urandom_range(0, 7));
      push_valid = 8'($urandom);
      pop_ready  = 8'($urandom);
      ovf_clr    = 8'($urandom) & 8'($urandom);
      for (int i = 0; i < N; i++) push_data[i] = 8'($urandom);
      step();
    end
    drain();
    step();
    check_eq("sb_empty_at_end", 32'(sb_q.size()), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
